// File: rtl/if_fetch_pkg.sv
// rtl/if_fetch_pkg.sv - shared encodings for the instruction-fetch stage
package if_fetch_pkg;

  localparam logic [1:0]  IF_FETCH = 2'd0;
  localparam logic [1:0]  IF_HOLD  = 2'd1;
  localparam logic [1:0]  IF_DRAIN = 2'd2;

  localparam logic [31:0] INST_NOP = 32'h0000_0013;

  function automatic logic [31:0] pc_inc(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/if_fetch_hold_buf.sv
// rtl/if_fetch_hold_buf.sv - one-entry instruction buffer used while IF/ID is stalled
module if_hold_buf
  import if_fetch_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        load_i,
  input  logic        clear_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o
);

  logic [31:0] data_q;

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      data_q <= INST_NOP;
    end else if (load_i) begin
      data_q <= data_i;
    end
  end

  assign data_o = data_q;

endmodule

// File: rtl/if_fetch.sv
// rtl/if_fetch.sv - PC register, imem request and IF/ID register with redirect/stall/flush
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        ifid_valid,
  output logic [31:0] ifid_pc,
  output logic [31:0] ifid_inst
);

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] drain_addr_q, drain_addr_d;
  logic        ifid_valid_q, ifid_valid_d;
  logic [31:0] ifid_pc_q, ifid_pc_d;
  logic [31:0] ifid_inst_q, ifid_inst_d;
  logic        buf_load, buf_clear;
  logic [31:0] buf_data;
  logic        unused_redirect_lsb;

  assign unused_redirect_lsb = ^redirect_pc[1:0];

  if_hold_buf u_hold_buf (
    .clk_i   (clk),
    .rst_i   (rst),
    .load_i  (buf_load),
    .clear_i (buf_clear),
    .data_i  (imem_rdata),
    .data_o  (buf_data)
  );

  // DRAIN keeps presenting the abandoned address so the memory sees a stable request.
  assign imem_req  = !rst && (state_q != IF_HOLD);
  assign imem_addr = (state_q == IF_DRAIN) ? drain_addr_q : pc_q;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    drain_addr_d = drain_addr_q;
    ifid_valid_d = ifid_valid_q;
    ifid_pc_d    = ifid_pc_q;
    ifid_inst_d  = ifid_inst_q;
    buf_load     = 1'b0;
    buf_clear    = 1'b0;

    if (redirect) begin
      ifid_valid_d = 1'b0;
      pc_d         = {redirect_pc[31:2], 2'b00};
      case (state_q)
        IF_FETCH: begin
          if (!imem_ack) begin
            state_d      = IF_DRAIN;
            drain_addr_d = pc_q;
          end
        end
        IF_HOLD: begin
          buf_clear = 1'b1;
          state_d   = IF_FETCH;
        end
        default: state_d = IF_DRAIN;
      endcase
    end else begin
      case (state_q)
        IF_FETCH: begin
          if (imem_ack && !stall) begin
            ifid_valid_d = 1'b1;
            ifid_pc_d    = pc_q;
            ifid_inst_d  = imem_rdata;
            pc_d         = pc_inc(pc_q);
          end else if (imem_ack) begin
            buf_load = 1'b1;
            state_d  = IF_HOLD;
          end else if (!stall) begin
            ifid_valid_d = 1'b0;
          end
        end
        IF_HOLD: begin
          if (!stall) begin
            ifid_valid_d = 1'b1;
            ifid_pc_d    = pc_q;
            ifid_inst_d  = buf_data;
            pc_d         = pc_inc(pc_q);
            buf_clear    = 1'b1;
            state_d      = IF_FETCH;
          end
        end
        default: begin
          ifid_valid_d = 1'b0;
          if (imem_ack) begin
            state_d = IF_FETCH;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IF_FETCH;
      pc_q         <= RESET_PC;
      drain_addr_q <= RESET_PC;
      ifid_valid_q <= 1'b0;
      ifid_pc_q    <= 32'h0;
      ifid_inst_q  <= INST_NOP;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      drain_addr_q <= drain_addr_d;
      ifid_valid_q <= ifid_valid_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_inst_q  <= ifid_inst_d;
    end
  end

  assign ifid_valid = ifid_valid_q;
  assign ifid_pc    = ifid_pc_q;
  assign ifid_inst  = ifid_inst_q;

endmodule

// File: tb/tb_if_fetch.sv
// tb/tb_if_fetch.sv - directed self-checking bench for if_fetch
module tb_if_fetch;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        stall = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata;
  logic        ifid_valid;
  logic [31:0] ifid_pc;
  logic [31:0] ifid_inst;

  int n_cmp = 0;
  int n_fail = 0;

  if_fetch #(.RESET_PC(32'h100)) dut (
    .clk         (clk),
    .rst         (rst),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .stall       (stall),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .ifid_valid  (ifid_valid),
    .ifid_pc     (ifid_pc),
    .ifid_inst   (ifid_inst)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  assign imem_rdata = mem_word(imem_addr);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; redirect = 1'b0; stall = 1'b0; imem_ack = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; redirect = 1'b0; stall = 1'b0; imem_ack = 1'b0;
    tick();
    tick();
    n_cmp++; if (ifid_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid got=%0b exp=0", ifid_valid); end
    n_cmp++; if (ifid_pc !== 32'h0) begin n_fail++; $display("FAIL rst_pc got=%h exp=0", ifid_pc); end
    n_cmp++; if (ifid_inst !== NOP) begin n_fail++; $display("FAIL rst_inst got=%h exp=%h", ifid_inst, NOP); end
    n_cmp++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL rst_req got=%0b exp=0", imem_req); end
    rst = 1'b0;
    imem_ack = 1'b1;
    #1;
    n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin n_fail++; $display("FAIL first_req got=%0b/%h exp=1/100", imem_req, imem_addr); end
  endtask

  task automatic test_stream();
    logic [31:0] exp_pc;
    do_reset();
    imem_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      exp_pc = 32'h100 + 32'(i * 4);
      n_cmp++; if (imem_addr !== exp_pc) begin n_fail++; $display("FAIL stream_addr%0d got=%h exp=%h", i, imem_addr, exp_pc); end
      tick();
      n_cmp++; if (ifid_valid !== 1'b1 || ifid_pc !== exp_pc || ifid_inst !== mem_word(exp_pc)) begin
        n_fail++; $display("FAIL stream_ifid%0d got=%0b/%h/%h exp=1/%h/%h", i, ifid_valid, ifid_pc, ifid_inst, exp_pc, mem_word(exp_pc));
      end
    end
  endtask

  task automatic test_stall_hold();
    do_reset();
    imem_ack = 1'b1;
    tick();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      imem_ack = 1'b0;
      n_cmp++; if (imem_req !== 1'b0 || ifid_pc !== 32'h100 || ifid_valid !== 1'b1) begin
        n_fail++; $display("FAIL hold%0d got req=%0b pc=%h v=%0b exp req=0 pc=100 v=1", i, imem_req, ifid_pc, ifid_valid);
      end
    end
    stall = 1'b0;
    imem_ack = 1'b1;
    tick();
    n_cmp++; if (ifid_valid !== 1'b1 || ifid_pc !== 32'h104 || ifid_inst !== mem_word(32'h104)) begin
      n_fail++; $display("FAIL hold_release got=%0b/%h/%h exp=1/104/%h", ifid_valid, ifid_pc, ifid_inst, mem_word(32'h104));
    end
    n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h108) begin n_fail++; $display("FAIL hold_next_addr got=%0b/%h exp=1/108", imem_req, imem_addr); end
  endtask

  task automatic test_drain();
    do_reset();
    imem_ack = 1'b1;
    tick(); tick(); tick();
    imem_ack = 1'b0;
    tick();
    n_cmp++; if (ifid_valid !== 1'b0 || imem_addr !== 32'h10C) begin n_fail++; $display("FAIL wait_bubble got=%0b/%h exp=0/10c", ifid_valid, imem_addr); end
    redirect = 1'b1; redirect_pc = 32'h200;
    tick();
    redirect = 1'b0;
    for (int i = 0; i < 2; i++) begin
      n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h10C || ifid_valid !== 1'b0) begin
        n_fail++; $display("FAIL drain%0d got req=%0b addr=%h v=%0b exp 1/10c/0", i, imem_req, imem_addr, ifid_valid);
      end
      if (i == 1) imem_ack = 1'b1;
      else tick();
    end
    tick();
    n_cmp++; if (ifid_valid !== 1'b0 || imem_addr !== 32'h200) begin n_fail++; $display("FAIL drain_exit got=%0b/%h exp=0/200", ifid_valid, imem_addr); end
    tick();
    n_cmp++; if (ifid_valid !== 1'b1 || ifid_pc !== 32'h200 || ifid_inst !== mem_word(32'h200)) begin
      n_fail++; $display("FAIL drain_first got=%0b/%h/%h exp=1/200/%h", ifid_valid, ifid_pc, ifid_inst, mem_word(32'h200));
    end
  endtask

  task automatic test_redirect_stall();
    do_reset();
    imem_ack = 1'b1;
    tick();
    redirect = 1'b1; stall = 1'b1; redirect_pc = 32'h203;
    tick();
    redirect = 1'b0; stall = 1'b0;
    n_cmp++; if (ifid_valid !== 1'b0 || imem_addr !== 32'h200) begin n_fail++; $display("FAIL redir_stall got=%0b/%h exp=0/200", ifid_valid, imem_addr); end
    tick();
    n_cmp++; if (ifid_valid !== 1'b1 || ifid_pc !== 32'h200) begin n_fail++; $display("FAIL redir_penalty got=%0b/%h exp=1/200", ifid_valid, ifid_pc); end
  endtask

  task automatic test_hold_redirect();
    do_reset();
    imem_ack = 1'b1;
    tick();
    stall = 1'b1;
    tick();
    imem_ack = 1'b0;
    redirect = 1'b1; redirect_pc = 32'h300;
    tick();
    redirect = 1'b0; stall = 1'b0; imem_ack = 1'b1;
    n_cmp++; if (ifid_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h300) begin
      n_fail++; $display("FAIL hold_redir got=%0b/%0b/%h exp=0/1/300", ifid_valid, imem_req, imem_addr);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    imem_ack = 1'b1;
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    tick();
    redirect = 1'b0;
    n_cmp++; if (imem_addr !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_addr got=%h exp=fffffffc", imem_addr); end
    tick();
    n_cmp++; if (imem_addr !== 32'h0 || ifid_pc !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_next got=%h/%h exp=0/fffffffc", imem_addr, ifid_pc); end
  endtask

  task automatic test_reset_in_hold();
    do_reset();
    imem_ack = 1'b1;
    tick();
    stall = 1'b1;
    tick();
    imem_ack = 1'b0;
    rst = 1'b1;
    tick();
    n_cmp++; if (ifid_valid !== 1'b0 || ifid_inst !== NOP || imem_req !== 1'b0) begin
      n_fail++; $display("FAIL hold_rst got=%0b/%h/%0b exp=0/%h/0", ifid_valid, ifid_inst, imem_req, NOP);
    end
    rst = 1'b0; stall = 1'b0; imem_ack = 1'b1;
    #1;
    n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin n_fail++; $display("FAIL hold_rst_release got=%0b/%h exp=1/100", imem_req, imem_addr); end
    tick();
    n_cmp++; if (ifid_valid !== 1'b1 || ifid_pc !== 32'h100) begin n_fail++; $display("FAIL hold_rst_first got=%0b/%h exp=1/100", ifid_valid, ifid_pc); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall_hold();
    test_drain();
    test_redirect_stall();
    test_hold_redirect();
    test_wrap();
    test_reset_in_hold();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
